vec_stream_loader: RTL and testbench

Assembles a serial stream of IWIDTH-bit elements into NINPUTS-element vectors and presents each complete vector in parallel to the vector-halving stage directly downstream. Two vector banks (ping-pong) let the next vector load while the downstream stage holds the current one. Both sides use valid/ready handshakes. The block is the entry point of the vector datapath, fed by the host/UART byte-to-element front end.

---
 rtl/vec_pkg.sv | 17 +
 rtl/vec_bank.sv | 26 ++
 rtl/vec_stream_loader.sv | 123 ++++++++++++
 tb/tb_vec_stream_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector datapath types and sizes for the loader and the halving stage.
package vec_pkg;

  localparam int IWIDTH  = 10;
  localparam int NINPUTS = 8;

  // Width of an element index; a single-bit counter is the floor even for tiny vectors
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(NINPUTS);

  typedef logic [IWIDTH-1:0] elem_t;
  typedef elem_t vec_t [NINPUTS];

endpackage

// File: rtl/vec_bank.sv
// One vector's worth of element storage: indexed single-element write, whole-vector read.
module vec_bank
  import vec_pkg::*;
#(
  parameter int IWIDTH  = vec_pkg::IWIDTH,
  parameter int NINPUTS = vec_pkg::NINPUTS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               we,
  input  logic [cnt_width(NINPUTS)-1:0]      waddr,
  input  logic [IWIDTH-1:0]                  wdata,
  output logic [IWIDTH-1:0]                  rdata [NINPUTS]
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NINPUTS; i++) begin
        rdata[i] <= '0;
      end
    end else if (we) begin
      rdata[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/vec_stream_loader.sv
// Serial-to-parallel vector loader with ping-pong banks and valid/ready on both sides.
// Optional framing check on in_last is enabled by defining VEC_LOADER_LAST_CHECK_EN.
module vec_stream_loader
  import vec_pkg::*;
#(
  parameter int IWIDTH  = vec_pkg::IWIDTH,
  parameter int NINPUTS = vec_pkg::NINPUTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IWIDTH-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [IWIDTH-1:0] out_data [NINPUTS],
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);

  localparam int            CW   = cnt_width(NINPUTS);
  localparam logic [CW-1:0] LAST = CW'(NINPUTS - 1);

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [CW-1:0] cnt;

  logic          in_fire;
  logic          out_fire;
  logic          drop;
  logic          we0;
  logic          we1;

  logic [IWIDTH-1:0] rdata0 [NINPUTS];
  logic [IWIDTH-1:0] rdata1 [NINPUTS];

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    we0 = 1'b0;
    we1 = 1'b0;
    if (in_fire) begin
      we0 = !wr_bank;
      we1 = wr_bank;
    end
  end

  vec_bank #(.IWIDTH(IWIDTH), .NINPUTS(NINPUTS)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we0),
    .waddr (cnt),
    .wdata (in_data),
    .rdata (rdata0)
  );

  vec_bank #(.IWIDTH(IWIDTH), .NINPUTS(NINPUTS)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we1),
    .waddr (cnt),
    .wdata (in_data),
    .rdata (rdata1)
  );

  // Output mux selects between two register banks, so out_* never sees in_* combinationally
  always_comb begin
    for (int i = 0; i < NINPUTS; i++) begin
      out_data[i] = rd_bank ? rdata1[i] : rdata0[i];
    end
  end

  // A vector transfer only ever touches the full read bank and an element transfer
  // only the empty write bank, so both updates to full[] can land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (out_fire) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (in_fire) begin
        if (drop) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt           <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

`ifdef VEC_LOADER_LAST_CHECK_EN
  // A short vector is thrown away; a long one is still committed, but both are flagged
  assign drop = in_last && (cnt != LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (in_fire && (in_last != (cnt == LAST))) begin
      frame_err <= 1'b1;
    end
  end
`else
  logic unused_last;

  assign drop        = 1'b0;
  assign frame_err   = 1'b0;
  assign unused_last = in_last;
`endif

endmodule

// File: tb/tb_vec_stream_loader.sv
// Randomized and directed bench for vec_stream_loader against a queue-based vector model.
// Define VEC_LOADER_LAST_CHECK_EN here as for the RTL to exercise the framing check.
module tb_vec_stream_loader;

  localparam int IW = 10;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [IW-1:0] out_data [N];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          frame_err;

  int checks = 0;
  int failures = 0;

  // Model: complete vectors awaiting consumption (oldest first) plus the partial one
  logic [IW*N-1:0] pend [$];
  logic [IW*N-1:0] partVec = '0;
  int              partCnt = 0;
  logic            modelErr = 1'b0;
  int              lastSeen = 0;

  always #5 clk = ~clk;

  vec_stream_loader #(.IWIDTH(IW), .NINPUTS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Two undelivered vectors means both banks are occupied
  task automatic checkAll();
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, pend.size() < 2});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, pend.size() > 0});
    checkOutput("frame_err", {31'd0, frame_err}, {31'd0, modelErr});
    if (pend.size() > 0) begin
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("out_data[%0d]", i), {22'd0, out_data[i]}, {22'd0, pend[0][i*IW +: IW]});
      end
    end
  endtask

  task automatic modelElement(input logic [IW-1:0] d, input logic l);
    lastSeen += int'(l);
`ifdef VEC_LOADER_LAST_CHECK_EN
    if (l && partCnt < N-1) begin
      partCnt  = 0;
      modelErr = 1'b1;
      return;
    end
    if (!l && partCnt == N-1) modelErr = 1'b1;
`endif
    partVec[partCnt*IW +: IW] = d;
    partCnt++;
    if (partCnt == N) begin
      pend.push_back(partVec);
      partCnt = 0;
    end
  endtask

  // One cycle: check the settled outputs, drive new inputs, advance the model
  task automatic applyStimulus(input logic v, input logic [IW-1:0] d, input logic l,
                               input logic r, output logic accepted);
    logic inFire;
    logic outFire;
    @(negedge clk);
    checkAll();
    rst_n     = 1'b1;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    inFire  = v && (pend.size() < 2);
    outFire = r && (pend.size() > 0);
    accepted = inFire;
    if (outFire) void'(pend.pop_front());
    if (inFire) modelElement(d, l);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pend.delete();
    partCnt  = 0;
    modelErr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("rst_out_data[%0d]", i), {22'd0, out_data[i]}, 32'd0);
    end
  endtask

  // Feeds consecutive values with correctly placed in_last, retrying stalled elements
  task automatic feedSeq(input int first, input int count, input logic r, input int budget);
    int idx;
    int c;
    logic acc;
    idx = first;
    c = 0;
    while (idx < first + count && c < budget) begin
      applyStimulus(1'b1, IW'(idx), partCnt == N-1, r, acc);
      if (acc) idx++;
      c++;
    end
    checkOutput("feed_done", idx, first + count);
  endtask

  task automatic idle(input int cycles, input logic r);
    logic acc;
    for (int c = 0; c < cycles; c++) applyStimulus(1'b0, '0, 1'b0, r, acc);
  endtask

  initial begin
    logic acc;
    int idx;

    applyReset();

    // Single vector 0..7 drained immediately
    feedSeq(0, 8, 1'b1, 8);
    idle(3, 1'b1);

    // Stall with out_ready low, then release and drain in order
    idx = 1;
    for (int c = 0; c < 80 && idx <= 24; c++) begin
      applyStimulus(1'b1, IW'(idx), partCnt == N-1, c >= 30, acc);
      if (acc) idx++;
    end
    checkOutput("stall_all_fed", idx, 25);
    idle(6, 1'b1);

    // Second vector completes in the very cycle the first is consumed
    feedSeq(100, 8, 1'b0, 8);
    feedSeq(200, 7, 1'b0, 7);
    applyStimulus(1'b1, IW'(207), 1'b1, 1'b1, acc);
    checkOutput("simul_accept", {31'd0, acc}, 32'd1);
    idle(4, 1'b1);

    // Both banks held while in_data keeps changing
    feedSeq(300, 16, 1'b0, 16);
    for (int c = 0; c < 20; c++) applyStimulus(1'b1, IW'($urandom), $urandom_range(0, 1) == 1, 1'b0, acc);
    idle(4, 1'b1);

    // Reset part-way through a vector
    feedSeq(400, 5, 1'b1, 5);
    applyReset();
    feedSeq(500, 8, 1'b1, 8);
    idle(3, 1'b1);

`ifdef VEC_LOADER_LAST_CHECK_EN
    // Short vector then a well-formed one
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, IW'(600 + i), i == 3, 1'b1, acc);
    idle(2, 1'b1);
    feedSeq(700, 8, 1'b1, 8);
    idle(3, 1'b1);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic v;
      logic r;
      logic l;
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
`ifdef VEC_LOADER_LAST_CHECK_EN
      l = (partCnt == N-1) ^ (($urandom % 16) == 0);
`else
      l = $urandom_range(0, 1) == 1;
`endif
      applyStimulus(v, IW'($urandom), l, r, acc);
    end
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
